// File: rtl/fsm_slave_if.sv
// Register-side and SCL signals of the I2C responder, grouped for the fsm_slave port list.
// SDA stays a discrete open-drain pin on the module because it is a resolved tri-state net.
interface fsm_slave_if #(
    parameter int unsigned DATA_LEN = 8
);
    logic                scl;
    logic [DATA_LEN-1:0] tx_data_1;
    logic [DATA_LEN-1:0] tx_data_2;
    logic [DATA_LEN-1:0] rx_data_1;
    logic [DATA_LEN-1:0] rx_data_2;
    logic                rx_valid;
    logic                tx_done;
    logic                busy;

    modport slave (
        input  scl, tx_data_1, tx_data_2,
        output rx_data_1, rx_data_2, rx_valid, tx_done, busy
    );

    modport master (
        output scl, tx_data_1, tx_data_2,
        input  rx_data_1, rx_data_2, rx_valid, tx_done, busy
    );
endinterface

// File: rtl/fsm_slave.sv
// I2C target: fixed 7-bit address, two-byte write or two-byte read, no clock stretching.
// SCL/SDA are synchronized and edge-detected; SDA drive only changes after an SCL fall event.
module fsm_slave #(
    parameter int unsigned         ADDR_LEN   = 7,
    parameter int unsigned         DATA_LEN   = 8,
    parameter logic [ADDR_LEN-1:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        sda,
    fsm_slave_if.slave bus
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } state_t;

    state_t state_q, state_d;

    logic scl_s1_q, scl_s2_q, scl_h_q;
    logic sda_s1_q, sda_s2_q, sda_h_q;

    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic                byte_q, byte_d;
    logic                phase_q, phase_d;
    logic                rw_q, rw_d;
    logic [DATA_LEN-1:0] shift_q, shift_d;
    logic [DATA_LEN-1:0] rx1_q, rx1_d;
    logic [DATA_LEN-1:0] rx2_q, rx2_d;
    logic                sda_low_q, sda_low_d;
    logic                rx_valid_q, rx_valid_d;
    logic                tx_done_q, tx_done_d;
    logic                busy_q, busy_d;

    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_rise  = scl_s2_q & ~scl_h_q;
    assign scl_fall  = ~scl_s2_q & scl_h_q;
    // START/STOP require SCL steady high; a coincident SCL edge makes it a data edge
    assign start_det = ~sda_s2_q & sda_h_q & scl_s2_q & scl_h_q;
    assign stop_det  = sda_s2_q & ~sda_h_q & scl_s2_q & scl_h_q;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_d     = byte_q;
        phase_d    = phase_q;
        rw_d       = rw_q;
        shift_d    = shift_q;
        rx1_d      = rx1_q;
        rx2_d      = rx2_q;
        sda_low_d  = sda_low_q;
        rx_valid_d = 1'b0;
        tx_done_d  = 1'b0;
        busy_d     = busy_q;

        if (stop_det) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            sda_low_d = 1'b0;
            phase_d   = 1'b0;
        end else if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            byte_d    = 1'b0;
            phase_d   = 1'b0;
            sda_low_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: sda_low_d = 1'b0;

                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[DATA_LEN-2:0], sda_s2_q};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == LAST_BIT) begin
                            rw_d = sda_s2_q;
                            if (shift_q[ADDR_LEN-1:0] == SLAVE_ADDR) begin
                                state_d = ADDR_ACK;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end

                // phase_q marks that the ACK low has been driven; the next fall releases it
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_low_d = 1'b1;
                            phase_d   = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if (rw_q) begin
                                shift_d   = bus.tx_data_1;
                                sda_low_d = ~bus.tx_data_1[DATA_LEN-1];
                                state_d   = RD_DATA;
                            end else begin
                                sda_low_d = 1'b0;
                                state_d   = WR_DATA;
                            end
                        end
                    end
                end

                WR_DATA: begin
                    if (scl_rise) begin
                        if (byte_q) rx2_d = {rx2_q[DATA_LEN-2:0], sda_s2_q};
                        else        rx1_d = {rx1_q[DATA_LEN-2:0], sda_s2_q};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == LAST_BIT) state_d = WR_ACK;
                    end
                end

                WR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_low_d = 1'b1;
                            phase_d   = 1'b1;
                        end else begin
                            phase_d   = 1'b0;
                            sda_low_d = 1'b0;
                            if (byte_q) begin
                                rx_valid_d = 1'b1;
                                state_d    = IGNORE;
                            end else begin
                                byte_d  = 1'b1;
                                state_d = WR_DATA;
                            end
                        end
                    end
                end

                // The current bit is already on the line; each fall presents the next one
                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = '0;
                            sda_low_d = 1'b0;
                            state_d   = RD_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            shift_d   = {shift_q[DATA_LEN-2:0], 1'b0};
                            sda_low_d = ~shift_q[DATA_LEN-2];
                        end
                    end
                end

                RD_ACK: begin
                    if (scl_rise) begin
                        if (byte_q) begin
                            tx_done_d = 1'b1;
                            state_d   = IGNORE;
                        end else if (sda_s2_q) begin
                            state_d = IGNORE;
                        end else begin
                            shift_d = bus.tx_data_2;
                            phase_d = 1'b1;
                        end
                    end else if (scl_fall && phase_q) begin
                        phase_d   = 1'b0;
                        byte_d    = 1'b1;
                        sda_low_d = ~shift_q[DATA_LEN-1];
                        state_d   = RD_DATA;
                    end
                end

                IGNORE: sda_low_d = 1'b0;

                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_h_q    <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_h_q    <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            byte_q     <= 1'b0;
            phase_q    <= 1'b0;
            rw_q       <= 1'b0;
            shift_q    <= '0;
            rx1_q      <= '0;
            rx2_q      <= '0;
            sda_low_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_done_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_s1_q   <= bus.scl;
            scl_s2_q   <= scl_s1_q;
            scl_h_q    <= scl_s2_q;
            sda_s1_q   <= sda;
            sda_s2_q   <= sda_s1_q;
            sda_h_q    <= sda_s2_q;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_q     <= byte_d;
            phase_q    <= phase_d;
            rw_q       <= rw_d;
            shift_q    <= shift_d;
            rx1_q      <= rx1_d;
            rx2_q      <= rx2_d;
            sda_low_q  <= sda_low_d;
            rx_valid_q <= rx_valid_d;
            tx_done_q  <= tx_done_d;
            busy_q     <= busy_d;
        end
    end

    assign sda           = sda_low_q ? 1'b0 : 1'bz;
    assign bus.rx_data_1 = rx1_q;
    assign bus.rx_data_2 = rx2_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.tx_done   = tx_done_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fsm_slave.sv
// Bit-banged I2C master driving fsm_slave; expected write/read results go into queues
// that a monitor pops whenever the responder pulses rx_valid or tx_done.
module tb_fsm_slave;
    localparam int HALF = 10;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic m_low = 1'b0;

    wire sda;
    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    fsm_slave_if #(.DATA_LEN(8)) bus ();

    fsm_slave #(.ADDR_LEN(7), .DATA_LEN(8), .SLAVE_ADDR(7'h50)) dut (
        .clk (clk),
        .rst (rst),
        .sda (sda),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int slave_low_cnt = 0;
    logic [15:0] exp_rx[$];
    logic [15:0] exp_tx[$];
    logic [7:0]  rd_b0 = '0;
    logic [7:0]  rd_b1 = '0;
    logic        rxv_prev = 1'b0;
    logic        txd_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Counts cycles where SDA is low without the master pulling it
    always @(posedge clk) begin
        if (!rst && sda === 1'b0 && !m_low) slave_low_cnt++;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_valid) begin
                chk("rx_valid_width", 32'(rxv_prev), 32'd0);
                if (exp_rx.size() == 0) chk("rx_valid_unexpected", 32'(bus.rx_valid), 32'd0);
                else chk("rx_data_pair", 32'({bus.rx_data_1, bus.rx_data_2}), 32'(exp_rx.pop_front()));
            end
            if (bus.tx_done) begin
                chk("tx_done_width", 32'(txd_prev), 32'd0);
                if (exp_tx.size() == 0) chk("tx_done_unexpected", 32'(bus.tx_done), 32'd0);
                else chk("read_bytes", 32'({rd_b0, rd_b1}), 32'(exp_tx.pop_front()));
            end
            rxv_prev = bus.rx_valid;
            txd_prev = bus.tx_done;
        end
    end

    task automatic w(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        w(3); m_low = 1'b0;
        w(HALF - 3); bus.scl = 1'b1;
        w(HALF); m_low = 1'b1;
        w(HALF); bus.scl = 1'b0;
    endtask

    task automatic bus_stop();
        w(3); m_low = 1'b1;
        w(HALF - 3); bus.scl = 1'b1;
        w(HALF); m_low = 1'b0;
        w(HALF);
    endtask

    task automatic write_bit(input logic b);
        w(3); m_low = ~b;
        w(HALF - 3); bus.scl = 1'b1;
        w(HALF); bus.scl = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        w(3); m_low = 1'b0;
        w(HALF - 3); bus.scl = 1'b1;
        w(HALF / 2); b = sda;
        w(HALF - HALF / 2); bus.scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_data(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        bus.scl = 1'b1;
        bus.tx_data_1 = 8'h00;
        bus.tx_data_2 = 8'h00;
        w(4);
        chk("reset_rx1", 32'(bus.rx_data_1), 32'h0);
        chk("reset_rx2", 32'(bus.rx_data_2), 32'h0);
        chk("reset_busy", 32'(bus.busy), 32'h0);
        chk("reset_sda", 32'(sda), 32'h1);
        rst = 1'b0;
        w(4);

        // two-byte write to our address
        exp_rx.push_back(16'hA53C);
        bus_start();
        write_byte(8'hA0, ack); chk("wr_addr_ack", 32'(ack), 32'h1);
        chk("wr_busy", 32'(bus.busy), 32'h1);
        write_byte(8'hA5, ack); chk("wr_b0_ack", 32'(ack), 32'h1);
        write_byte(8'h3C, ack); chk("wr_b1_ack", 32'(ack), 32'h1);
        bus_stop();
        chk("wr_busy_after_stop", 32'(bus.busy), 32'h0);
        chk("wr_rx1", 32'(bus.rx_data_1), 32'hA5);
        chk("wr_rx_pending", 32'(exp_rx.size()), 32'h0);

        // write to a foreign address
        slave_low_cnt = 0;
        bus_start();
        write_byte(8'hA2, ack); chk("other_addr_ack", 32'(ack), 32'h0);
        write_byte(8'h77, ack); chk("other_data_ack", 32'(ack), 32'h0);
        bus_stop();
        chk("other_sda_driven", 32'(slave_low_cnt), 32'h0);
        chk("other_busy", 32'(bus.busy), 32'h0);
        chk("other_rx1", 32'(bus.rx_data_1), 32'hA5);
        chk("other_rx2", 32'(bus.rx_data_2), 32'h3C);

        // two-byte read, ACK then NACK
        bus.tx_data_1 = 8'hC3;
        bus.tx_data_2 = 8'h81;
        exp_tx.push_back(16'hC381);
        bus_start();
        write_byte(8'hA1, ack); chk("rd_addr_ack", 32'(ack), 32'h1);
        read_data(d); rd_b0 = d; write_bit(1'b0);
        read_data(d); rd_b1 = d; write_bit(1'b1);
        chk("rd_b0", 32'(rd_b0), 32'hC3);
        chk("rd_b1", 32'(rd_b1), 32'h81);
        chk("rd_sda_released", 32'(sda), 32'h1);
        bus_stop();
        chk("rd_tx_pending", 32'(exp_tx.size()), 32'h0);
        chk("rd_busy_after_stop", 32'(bus.busy), 32'h0);

        // read with NACK on the first byte
        bus.tx_data_1 = 8'h5A;
        bus.tx_data_2 = 8'h00;
        bus_start();
        write_byte(8'hA1, ack); chk("nack_addr_ack", 32'(ack), 32'h1);
        read_data(d); chk("nack_b0", 32'(d), 32'h5A);
        write_bit(1'b1);
        read_data(d); chk("nack_b1_released", 32'(d), 32'hFF);
        write_bit(1'b1);
        bus_stop();
        chk("nack_busy", 32'(bus.busy), 32'h0);

        // aborted write followed by a repeated START
        exp_rx.push_back(16'h2233);
        bus_start();
        write_byte(8'hA0, ack); chk("abort_addr_ack", 32'(ack), 32'h1);
        write_byte(8'h11, ack); chk("abort_b0_ack", 32'(ack), 32'h1);
        bus_start();
        write_byte(8'hA0, ack); chk("rs_addr_ack", 32'(ack), 32'h1);
        write_byte(8'h22, ack); chk("rs_b0_ack", 32'(ack), 32'h1);
        write_byte(8'h33, ack); chk("rs_b1_ack", 32'(ack), 32'h1);
        bus_stop();
        chk("rs_rx1", 32'(bus.rx_data_1), 32'h22);
        chk("rs_rx2", 32'(bus.rx_data_2), 32'h33);
        chk("rs_rx_pending", 32'(exp_rx.size()), 32'h0);

        // reset in the middle of the address phase
        bus_start();
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        w(3); m_low = 1'b0;
        rst = 1'b1;
        w(1);
        chk("mid_rst_rx1", 32'(bus.rx_data_1), 32'h0);
        chk("mid_rst_rx2", 32'(bus.rx_data_2), 32'h0);
        chk("mid_rst_busy", 32'(bus.busy), 32'h0);
        chk("mid_rst_rx_valid", 32'(bus.rx_valid), 32'h0);
        chk("mid_rst_tx_done", 32'(bus.tx_done), 32'h0);
        chk("mid_rst_sda", 32'(sda), 32'h1);
        rst = 1'b0;
        w(4);
        exp_rx.push_back(16'h5AF0);
        bus_start();
        write_byte(8'hA0, ack); chk("post_rst_addr_ack", 32'(ack), 32'h1);
        write_byte(8'h5A, ack); chk("post_rst_b0_ack", 32'(ack), 32'h1);
        write_byte(8'hF0, ack); chk("post_rst_b1_ack", 32'(ack), 32'h1);
        bus_stop();
        chk("post_rst_rx_pending", 32'(exp_rx.size()), 32'h0);
        chk("post_rst_busy", 32'(bus.busy), 32'h0);
        chk("final_tx_pending", 32'(exp_tx.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
